// File: rtl/grid_pkg.sv
// -----------------------------------------------------------------------------
// grid_pkg
// Shared definitions for the game-grid subsystem: default grid coordinate
// width, the 2-bit cell codes stored in grid memory, and the state encoding of
// the grid update sequencer. The grid memory, the snake writer and the
// sequencer all import this package so the cell codes cannot drift apart.
// -----------------------------------------------------------------------------
package grid_pkg;

  // Coordinate width per axis; the grid is 2^GridBitsDefault squared cells.
  localparam int unsigned GridBitsDefault = 4;

  // Cell codes held in grid memory. 2'b11 is reserved and never written.
  typedef logic [1:0] cell_t;
  localparam cell_t CellEmpty = 2'b00;
  localparam cell_t CellSnake = 2'b01;
  localparam cell_t CellFood  = 2'b10;

  // Frame update sequence: wait for blanking, wipe the grid, paint the snake,
  // paint the food, then signal completion.
  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StWaitVbl = 3'd1,
    StClear   = 3'd2,
    StSnake   = 3'd3,
    StFood    = 3'd4,
    StDone    = 3'd5
  } state_e;

endpackage

// File: rtl/grid_update_sequencer.sv
// -----------------------------------------------------------------------------
// grid_update_sequencer
// Owns the grid-memory write port for one frame update per game tick. On a
// tick it latches the food cell, waits for vertical blanking, clears every
// cell to EMPTY, hands the write port to the snake writer until it signals the
// last cell (or hits the beat limit), writes the food cell and pulses
// frame_done. Ticks arriving while a frame is in progress are reported on
// overrun and otherwise ignored.
//
// Ports
//   clk                  clock, rising edge
//   reset                synchronous active-high reset
//   tick_in              one-cycle game tick
//   vblank               level, high during vertical blanking
//   snake_req            snake writer presents a cell this cycle
//   snake_x, snake_y     snake cell coordinates
//   snake_last           marks the final snake cell of the frame
//   snake_gnt            snake writer owns the write port (from state)
//   food_valid/x/y       food cell, sampled on an accepted tick
//   mem_we/x/y/data      registered grid-memory write port
//   busy                 high whenever not idle
//   frame_done           one-cycle pulse at the end of a frame update
//   overrun              one-cycle pulse for a tick that arrived while busy
// -----------------------------------------------------------------------------
module grid_update_sequencer
  import grid_pkg::*;
#(
  parameter int unsigned GRID_BITS = GridBitsDefault,
  parameter int unsigned MAX_SNAKE = 256
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 tick_in,
  input  logic                 vblank,
  input  logic                 snake_req,
  input  logic [GRID_BITS-1:0] snake_x,
  input  logic [GRID_BITS-1:0] snake_y,
  input  logic                 snake_last,
  output logic                 snake_gnt,
  input  logic                 food_valid,
  input  logic [GRID_BITS-1:0] food_x,
  input  logic [GRID_BITS-1:0] food_y,
  output logic                 mem_we,
  output logic [GRID_BITS-1:0] mem_x,
  output logic [GRID_BITS-1:0] mem_y,
  output logic [1:0]           mem_data,
  output logic                 busy,
  output logic                 frame_done,
  output logic                 overrun
);

  // One extra bit so the same counter can count MAX_SNAKE beats (256 at the
  // default size) as well as walk every cell during CLEAR.
  localparam int unsigned CntW = 2 * GRID_BITS + 1;

  state_e         state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  logic                 food_valid_q;
  logic [GRID_BITS-1:0] food_x_q, food_y_q;
  logic                 overrun_q;

  // Write decided this cycle; registered onto mem_* at the next edge.
  logic                 we_d;
  logic [GRID_BITS-1:0] wx_d, wy_d;
  cell_t                wdata_d;

  logic clear_last;
  logic snake_cap;

  assign clear_last = (cnt_q[2*GRID_BITS-1:0] == '1);
  // Accepting the beat at this count makes MAX_SNAKE beats in total.
  assign snake_cap  = (cnt_q == CntW'(MAX_SNAKE - 1));

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state and counter logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (tick_in) begin
          state_d = StWaitVbl;
        end
      end
      StWaitVbl: begin
        if (vblank) begin
          state_d = StClear;
          cnt_d   = '0;
        end
      end
      StClear: begin
        // vblank is no longer consulted: once started, the frame completes.
        if (clear_last) begin
          state_d = StSnake;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StSnake: begin
        if (snake_req) begin
          if (snake_last || snake_cap) begin
            state_d = StFood;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      StFood: begin
        state_d = StDone;
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output decode: status flags and the write to issue this cycle
  // ---------------------------------------------------------------------------
  always_comb begin
    snake_gnt  = 1'b0;
    busy       = (state_q != StIdle);
    frame_done = 1'b0;
    we_d       = 1'b0;
    wx_d       = '0;
    wy_d       = '0;
    wdata_d    = CellEmpty;
    unique case (state_q)
      StClear: begin
        we_d    = 1'b1;
        wx_d    = cnt_q[GRID_BITS-1:0];
        wy_d    = cnt_q[2*GRID_BITS-1:GRID_BITS];
        wdata_d = CellEmpty;
      end
      StSnake: begin
        snake_gnt = 1'b1;
        we_d      = snake_req;
        wx_d      = snake_x;
        wy_d      = snake_y;
        wdata_d   = CellSnake;
      end
      StFood: begin
        // Written after the snake, so food wins if the snake overlaps it.
        we_d    = food_valid_q;
        wx_d    = food_x_q;
        wy_d    = food_y_q;
        wdata_d = CellFood;
      end
      StDone: begin
        frame_done = 1'b1;
      end
      default: ;
    endcase
  end

  assign overrun = overrun_q;

  // ---------------------------------------------------------------------------
  // Food latch, overrun flag and registered write port
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      food_valid_q <= 1'b0;
      food_x_q     <= '0;
      food_y_q     <= '0;
      overrun_q    <= 1'b0;
      mem_we       <= 1'b0;
      mem_x        <= '0;
      mem_y        <= '0;
      mem_data     <= CellEmpty;
    end else begin
      // Food is captured only by a tick that actually starts a frame.
      if (state_q == StIdle && tick_in) begin
        food_valid_q <= food_valid;
        food_x_q     <= food_x;
        food_y_q     <= food_y;
      end
      overrun_q <= tick_in && (state_q != StIdle);
      mem_we    <= we_d;
      // Address and data hold their last values between writes.
      if (we_d) begin
        mem_x    <= wx_d;
        mem_y    <= wy_d;
        mem_data <= wdata_d;
      end
    end
  end

endmodule

// File: tb/tb_grid_update_sequencer.sv
// -----------------------------------------------------------------------------
// tb_grid_update_sequencer
// Randomised frames against a reference model that builds, from the rules of
// a frame update, the ordered list of expected grid writes and the expected
// final grid contents, and compares them with what the DUT wrote.
// -----------------------------------------------------------------------------
module tb_grid_update_sequencer;

  localparam int GB    = 4;
  localparam int SIDE  = 16;
  localparam int CELLS = 256;
  localparam int MAXS  = 256;

  typedef struct packed {
    logic [3:0] x;
    logic [3:0] y;
    logic [1:0] d;
  } wr_t;

  logic          clk = 1'b0;
  logic          reset;
  logic          tick_in, vblank;
  logic          snake_req, snake_last, snake_gnt;
  logic [GB-1:0] snake_x, snake_y;
  logic          food_valid;
  logic [GB-1:0] food_x, food_y;
  logic          mem_we;
  logic [GB-1:0] mem_x, mem_y;
  logic [1:0]    mem_data;
  logic          busy, frame_done, overrun;

  grid_update_sequencer #(
    .GRID_BITS(GB),
    .MAX_SNAKE(MAXS)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .tick_in   (tick_in),
    .vblank    (vblank),
    .snake_req (snake_req),
    .snake_x   (snake_x),
    .snake_y   (snake_y),
    .snake_last(snake_last),
    .snake_gnt (snake_gnt),
    .food_valid(food_valid),
    .food_x    (food_x),
    .food_y    (food_y),
    .mem_we    (mem_we),
    .mem_x     (mem_x),
    .mem_y     (mem_y),
    .mem_data  (mem_data),
    .busy      (busy),
    .frame_done(frame_done),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;
  int cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Monitor: everything the DUT writes, plus frame_done / overrun activity.
  wr_t        obs_q[$];
  logic [1:0] shadow[CELLS];
  int         n_done, n_ovr, first_we_cyc, done_cyc;

  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      obs_q.push_back('{x: mem_x, y: mem_y, d: mem_data});
      shadow[int'(mem_y) * SIDE + int'(mem_x)] = mem_data;
      if (first_we_cyc < 0) first_we_cyc = cyc;
    end
    if (frame_done === 1'b1) begin
      n_done++;
      done_cyc = cyc;
    end
    if (overrun === 1'b1) n_ovr++;
  end

  task automatic run_frame(input string tag, input bit fv, input int fx, input int fy,
                           input int nbeats, input bit with_last, input int max_gap,
                           input int vbl_delay, input int extra_tick, input bit hit_food,
                           input bit check_lat);
    int         bx[$], by[$], gp[$];
    wr_t        exp_q[$];
    logic [1:0] exp_grid[CELLS];
    int         acc, t0, tv, bi, gap_left, budget, we_cnt, nb_cnt, mis, lat;
    bit         done;

    for (int i = 0; i < nbeats; i++) begin
      bx.push_back((hit_food && i == 0) ? fx : int'($urandom_range(0, SIDE - 1)));
      by.push_back((hit_food && i == 0) ? fy : int'($urandom_range(0, SIDE - 1)));
      gp.push_back(max_gap > 0 ? int'($urandom_range(0, max_gap)) : 0);
    end

    // Reference: wipe all cells in raster order, paint accepted snake beats in
    // order, then paint food if it was valid at the tick.
    acc = with_last ? nbeats : ((nbeats < MAXS) ? nbeats : MAXS);
    for (int i = 0; i < CELLS; i++) begin
      exp_grid[i] = 2'b00;
      exp_q.push_back('{x: 4'(i % SIDE), y: 4'(i / SIDE), d: 2'b00});
    end
    for (int i = 0; i < acc; i++) begin
      exp_q.push_back('{x: 4'(bx[i]), y: 4'(by[i]), d: 2'b01});
      exp_grid[by[i] * SIDE + bx[i]] = 2'b01;
    end
    if (fv) begin
      exp_q.push_back('{x: 4'(fx), y: 4'(fy), d: 2'b10});
      exp_grid[fy * SIDE + fx] = 2'b10;
    end

    obs_q.delete();
    n_done = 0;
    n_ovr = 0;
    first_we_cyc = -1;
    for (int i = 0; i < CELLS; i++) shadow[i] = 2'b11;

    @(negedge clk);
    tick_in    = 1'b1;
    food_valid = fv;
    food_x     = 4'(fx);
    food_y     = 4'(fy);
    vblank     = (vbl_delay == 0);
    t0 = cyc;
    tv = cyc;
    @(negedge clk);
    tick_in    = 1'b0;
    food_valid = 1'($urandom);
    food_x     = 4'($urandom);
    food_y     = 4'($urandom);

    if (vbl_delay > 0) begin
      we_cnt = 0;
      nb_cnt = 0;
      for (int i = 0; i < vbl_delay; i++) begin
        if (mem_we !== 1'b0) we_cnt++;
        if (busy !== 1'b1) nb_cnt++;
        @(negedge clk);
      end
      check_val({tag, "_we_in_wait"}, we_cnt, 0);
      check_val({tag, "_idle_in_wait"}, nb_cnt, 0);
      vblank = 1'b1;
      tv = cyc;
    end

    bi = 0;
    gap_left = (nbeats > 0) ? gp[0] : 0;
    budget = 4000;
    done = 1'b0;
    while (!done && budget > 0) begin
      if (extra_tick > 0 && cyc == t0 + extra_tick) begin
        tick_in    = 1'b1;
        food_valid = ~fv;
        food_x     = 4'(fx ^ 15);
        food_y     = 4'(fy ^ 15);
      end else begin
        tick_in = 1'b0;
      end
      if (first_we_cyc >= 0) vblank = 1'($urandom_range(0, 1));
      if (snake_gnt === 1'b1 && bi < nbeats) begin
        if (gap_left > 0) begin
          snake_req  = 1'b0;
          snake_last = 1'($urandom);
          snake_x    = 4'($urandom);
          snake_y    = 4'($urandom);
          gap_left--;
        end else begin
          snake_req  = 1'b1;
          snake_x    = 4'(bx[bi]);
          snake_y    = 4'(by[bi]);
          snake_last = with_last && (bi == nbeats - 1);
          bi++;
          gap_left = (bi < nbeats) ? gp[bi] : 0;
        end
      end else begin
        snake_req  = 1'b0;
        snake_last = 1'b0;
      end
      if (frame_done === 1'b1) done = 1'b1;
      budget--;
      @(negedge clk);
    end
    tick_in   = 1'b0;
    snake_req = 1'b0;
    vblank    = 1'b0;
    repeat (3) @(negedge clk);

    if (!done) check_val({tag, "_timeout"}, 0, 1);
    check_val({tag, "_frame_done_cnt"}, n_done, 1);
    check_val({tag, "_overrun_cnt"}, n_ovr, (extra_tick > 0) ? 1 : 0);
    check_val({tag, "_write_cnt"}, obs_q.size(), exp_q.size());
    mis = 0;
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
      if (obs_q[i] !== exp_q[i]) mis++;
    check_val({tag, "_write_seq_miscompares"}, mis, 0);
    mis = 0;
    for (int i = 0; i < CELLS; i++)
      if (shadow[i] !== exp_grid[i]) mis++;
    check_val({tag, "_grid_cells_wrong"}, mis, 0);
    check_val({tag, "_clear_start"}, first_we_cyc - tv, (vbl_delay > 0) ? 2 : 3);
    if (check_lat) begin
      lat = done_cyc - t0;
      check_val({tag, "_latency_in_262_264"}, (lat >= 262 && lat <= 264), 1);
    end
  endtask

  initial begin
    int t0;
    int guard;

    reset      = 1'b1;
    tick_in    = 1'b0;
    vblank     = 1'b0;
    snake_req  = 1'b0;
    snake_last = 1'b0;
    snake_x    = '0;
    snake_y    = '0;
    food_valid = 1'b0;
    food_x     = '0;
    food_y     = '0;
    n_done = 0;
    n_ovr = 0;
    first_we_cyc = -1;
    done_cyc = 0;
    repeat (3) @(negedge clk);
    check_val("reset_outputs", {mem_we, snake_gnt, busy, frame_done, overrun}, 0);
    reset = 1'b0;
    @(negedge clk);
    check_val("idle_not_busy", busy, 0);

    // Directed frames.
    run_frame("basic", 1'b1, 5, 7, 3, 1'b1, 0, 0, 0, 1'b0, 1'b1);
    run_frame("vbl_wait", 1'b1, 2, 12, 4, 1'b1, 2, 100, 0, 1'b0, 1'b0);
    run_frame("overrun", 1'b1, 3, 9, 5, 1'b1, 1, 0, 50, 1'b0, 1'b0);
    run_frame("overrun_nofood", 1'b0, 8, 1, 2, 1'b1, 0, 3, 80, 1'b0, 1'b0);
    run_frame("forced_exit", 1'b1, 10, 4, 300, 1'b0, 0, 0, 0, 1'b0, 1'b0);

    // Reset in the middle of CLEAR, at cell counter 100.
    @(negedge clk);
    tick_in    = 1'b1;
    vblank     = 1'b1;
    food_valid = 1'b1;
    food_x     = 4'd1;
    food_y     = 4'd1;
    t0 = cyc;
    @(negedge clk);
    tick_in = 1'b0;
    guard = 0;
    while (cyc != t0 + 102 && guard < 500) begin
      guard++;
      @(negedge clk);
    end
    check_val("midframe_busy", busy, 1);
    reset = 1'b1;
    @(negedge clk);
    check_val("midframe_reset_outputs", {mem_we, snake_gnt, busy, frame_done, overrun}, 0);
    reset  = 1'b0;
    vblank = 1'b0;
    @(negedge clk);
    run_frame("post_reset", 1'b1, 14, 0, 6, 1'b1, 1, 2, 0, 1'b0, 1'b0);

    run_frame("no_food", 1'b0, 5, 7, 4, 1'b1, 2, 0, 0, 1'b0, 1'b0);
    run_frame("food_over_snake", 1'b1, 5, 7, 4, 1'b1, 1, 0, 0, 1'b1, 1'b0);
    check_val("cell_5_7_food", shadow[7 * SIDE + 5], 2'b10);

    // Randomised frames.
    for (int f = 0; f < 8; f++) begin
      run_frame("rand", 1'($urandom), int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                int'($urandom_range(1, 20)), 1'b1, int'($urandom_range(0, 3)),
                int'($urandom_range(0, 6)), 0, 1'($urandom), 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/grid_update_sequencer.md
GRID_UPDATE_SEQUENCER -- requirements
Module: grid_update_sequencer

Interface
REQ-001 Parameter GRID_BITS, default 4: coordinate width per axis; the grid is 2^GRID_BITS x 2^GRID_BITS cells.
REQ-002 Parameter MAX_SNAKE, default 256: maximum snake write beats accepted per frame.
REQ-003 clk  input  1: clock; all logic is on the rising edge.
REQ-004 reset  input  1: synchronous, active-high reset.
REQ-005 tick_in  input  1: one-cycle game-tick pulse in the clk domain.
REQ-006 vblank  input  1: level, high during VGA vertical blanking.
REQ-007 snake_req  input  1: snake writer has a valid cell this cycle.
REQ-008 snake_x, snake_y  input  GRID_BITS each: snake cell coordinates.
REQ-009 snake_last  input  1: marks the final snake cell of the frame.
REQ-010 snake_gnt  output  1: snake writer owns the write port (combinational from state).
REQ-011 food_valid, food_x, food_y  input  1/GRID_BITS/GRID_BITS: food cell, sampled at tick.
REQ-012 mem_we, mem_x, mem_y, mem_data  output  1/GRID_BITS/GRID_BITS/2: registered grid-memory write port.
REQ-013 busy  output  1: high in every state except IDLE.
REQ-014 frame_done  output  1: one-cycle pulse when a frame update completes.
REQ-015 overrun  output  1: one-cycle pulse when a tick arrives while busy.

Function
REQ-016 Cell codes: EMPTY=2'b00, SNAKE=2'b01, FOOD=2'b10; 2'b11 is never written.
REQ-017 FSM states: IDLE, WAIT_VBL, CLEAR, SNAKE, FOOD, DONE.
REQ-018 IDLE: tick_in=1 latches food_valid/x/y and moves to WAIT_VBL next cycle.
REQ-019 WAIT_VBL: stays until vblank=1, then moves to CLEAR with the cell counter at 0.
REQ-020 CLEAR: each cycle issues one write of EMPTY at x=cnt[GRID_BITS-1:0], y=cnt[2*GRID_BITS-1:GRID_BITS]; counter increments; leaves for SNAKE after the write at cnt=all-ones (256 writes at default).
REQ-021 SNAKE: snake_gnt=1; each cycle with snake_req=1 issues a write of SNAKE at snake_x/snake_y; snake_req=0 cycles issue no write.
REQ-022 SNAKE exits to FOOD on the beat where snake_req=1 and snake_last=1, or after MAX_SNAKE accepted beats (forced exit, no further grants).
REQ-023 FOOD: one cycle; issues a write of FOOD at the latched coordinates only if latched food_valid=1; then DONE.
REQ-024 DONE: one cycle; frame_done=1; then IDLE.
REQ-025 Write-port outputs are registered: a write decided in cycle N appears on mem_* in cycle N+1; mem_we=0 otherwise; mem_x/mem_y/mem_data hold their last values when mem_we=0.
REQ-026 Once CLEAR is entered, the sequence runs to completion regardless of vblank deasserting.
REQ-027 tick_in=1 in any state other than IDLE pulses overrun next cycle and is otherwise ignored; the latched food is unchanged.
REQ-028 tick_in=1 in the same cycle DONE is active counts as overrun; it does not start a new frame.
REQ-029 Snake write to the food cell: the later FOOD write wins (FOOD overwrites SNAKE).

Reset
REQ-030 reset=1 forces state IDLE, cell/beat counters 0, latched food cleared, and mem_we, snake_gnt, busy, frame_done, overrun all 0 on the next edge; it takes priority over all other inputs, including mid-frame.

Structure
REQ-031 Package grid_pkg holds GRID_BITS default, the cell-code constants, and the FSM state encoding; memory, snake writer and this block share it.
REQ-032 Single module, no sub-modules; one counter of 2*GRID_BITS+1 bits serves both CLEAR and the SNAKE beat count.

Verification
REQ-033 tick with vblank=1 held, 3 snake beats (last on 3rd), food (5,7) valid -> 256 EMPTY writes, 3 SNAKE writes, 1 FOOD write at (5,7); frame_done 263 cycles after tick ±1.
REQ-034 tick with vblank=0 for 100 cycles -> no mem_we and busy=1 throughout; CLEAR starts the cycle after vblank rises.
REQ-035 Second tick during CLEAR -> overrun pulses one cycle; exactly one frame_done; food coordinates from first tick.
REQ-036 snake_req held, snake_last never set -> exactly 256 SNAKE writes, then FOOD and frame_done.
REQ-037 reset asserted at CLEAR cnt=100 -> next cycle IDLE, all outputs 0; next tick runs a full 256-cell CLEAR.
REQ-038 food_valid=0 at tick -> no FOOD write; DONE follows FOOD state; snake beat at (5,7) then food (5,7) -> final memory cell (5,7)=FOOD.
